// File: rtl/memory_sync_param.sv
// memory_sync_param: parametrised single-clock memory with one write port and
// one registered read port. After reset a clear sequence zeroes every word
// while busy is high. Out-of-range accesses are flagged: wr_err for dropped
// writes, rd_err alongside rd_valid for reads, which return zero.
// Optional build macro MEM_RD_BYPASS_EN: a same-address, same-cycle
// read/write returns the incoming write data (write-first). Without it the
// read returns the old contents (read-first).
module memory_sync_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  output logic              busy
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  // The address is zero-extended by one bit so DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] rd_data;

  assign wr_in_range = ({1'b0, addr_wr} < DEPTH_X);
  assign rd_in_range = ({1'b0, addr_rd} < DEPTH_X);
  assign busy        = (state == CLEAR);

  // State and clear-pointer register; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state and write-port steering. The clear sequence and user writes
  // share the one write port: CLEAR owns it, RUN hands it to the requester.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = addr_wr;
    mem_wd     = data_in;
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        mem_wa   = ptr;
        mem_wd   = '0;
        ptr_next = ptr + 1'b1;
        if (ptr == LAST) begin
          state_next = RUN;
          ptr_next   = '0;
        end
      end
      RUN: begin
        accept = 1'b1;
        mem_we = write && wr_in_range;
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage array; no reset, contents are zeroed by the clear sequence.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read data selection, including the collision policy for this build.
  always_comb begin
    rd_data = mem[rd_in_range ? addr_rd : '0];
`ifdef MEM_RD_BYPASS_EN
    if (write && wr_in_range && (addr_wr == addr_rd)) begin
      rd_data = data_in;
    end
`endif
  end

  // Registered read result and one-cycle status strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= accept && read;
      rd_err   <= accept && read && !rd_in_range;
      wr_err   <= accept && write && !wr_in_range;
      if (accept && read) begin
        data_out <= rd_in_range ? rd_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_sync_param.sv
// Scoreboard bench for memory_sync_param (DEPTH=12, ADDR_W=4, so addresses
// 12..15 are out of range). The driver updates a behavioural model at each
// edge and queues expected responses; a monitor pops and compares them.
module tb_memory_sync_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr_wr = '0;
  logic [DW-1:0] data_in = '0;
  logic          read = 1'b0;
  logic [AW-1:0] addr_rd = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          rd_err;
  logic          wr_err;
  logic          busy;

  memory_sync_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .addr_wr(addr_wr),
    .data_in(data_in), .read(read), .addr_rd(addr_rd),
    .data_out(data_out), .rd_valid(rd_valid), .rd_err(rd_err),
    .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [DW-1:0] mmem [DP];
  logic [DW:0]   rdq [$];
  bit            wrq [$];
  bit            busy_m = 1'b1;
  int            clr_cnt = 0;
  logic [DW-1:0] exp_dout = '0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs, then at the edge apply the memory's rules to the model.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] aw,
                      input logic [DW-1:0] d, input logic rd, input logic [AW-1:0] ar);
    logic [DW-1:0] e;
    rst_n = r; write = w; addr_wr = aw; data_in = d; read = rd; addr_rd = ar;
    @(posedge clk);
    mon_en = 1'b1;
    if (!r) begin
      busy_m = 1'b1;
      clr_cnt = 0;
      foreach (mmem[i]) mmem[i] = '0;
      exp_dout = '0;
    end else if (busy_m) begin
      clr_cnt++;
      if (clr_cnt == DP) busy_m = 1'b0;
    end else begin
      if (rd) begin
        if (int'(ar) < DP) begin
          e = mmem[ar];
`ifdef MEM_RD_BYPASS_EN
          if (w && aw == ar) e = d;
`endif
          rdq.push_back({1'b0, e});
          exp_dout = e;
        end else begin
          rdq.push_back({1'b1, {DW{1'b0}}});
          exp_dout = '0;
        end
      end
      if (w) begin
        if (int'(aw) < DP) mmem[aw] = d;
        else wrq.push_back(1'b1);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rnd_step(input logic r);
    step(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
         1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
  endtask

  // Monitor: compares DUT outputs with the model shortly after every edge.
  always @(posedge clk) begin
    logic [DW:0] e;
    #1;
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(busy_m));
      chk("data_out", 32'(data_out), 32'(exp_dout));
      if (rd_valid === 1'b1) begin
        if (rdq.size() == 0) begin
          chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
        end else begin
          e = rdq.pop_front();
          chk("rd_data", 32'(data_out), 32'(e[DW-1:0]));
          chk("rd_err", 32'(rd_err), 32'(e[DW]));
        end
      end else begin
        chk("rd_err_idle", 32'(rd_err), 32'd0);
      end
      if (wr_err === 1'b1) begin
        if (wrq.size() == 0) chk("wr_err_spurious", 32'(wr_err), 32'd0);
        else void'(wrq.pop_front());
      end
      chk("rd_missing", 32'(rdq.size()), 32'd0);
      chk("wr_err_missing", 32'(wrq.size()), 32'd0);
    end
  end

  initial begin
    // Reset two edges, then a write to word 0 while clearing (must be ignored)
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 4'd0, 8'h77, 1'b1, 4'd0);
    idle(DP - 1);
    // Every word reads back zero
    for (int a = 0; a < DP; a++) step(1'b1, 1'b0, '0, '0, 1'b1, AW'(a));
    // Read-after-write, then hold
    step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd3);
    idle(3);
    // Out-of-range write and read
    step(1'b1, 1'b1, 4'd13, 8'hFF, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd13);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd15);
    // Collision on word 5
    step(1'b1, 1'b1, 4'd5, 8'h11, 1'b0, '0);
    step(1'b1, 1'b1, 4'd5, 8'h22, 1'b1, 4'd5);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd5);
    // Random traffic
    for (int i = 0; i < 300; i++) rnd_step(1'b1);
    // Fill everything, reset mid-burst, traffic during clear, then read all
    for (int a = 0; a < DP; a++) begin
      if (a == 6) rnd_step(1'b0);
      step(1'b1, 1'b1, AW'(a), DW'($urandom), 1'b1, AW'($urandom_range(0, 11)));
    end
    for (int i = 0; i < DP + 2; i++) rnd_step(1'b1);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, '0, '0, 1'b1, AW'(a));
    for (int i = 0; i < 200; i++) rnd_step(1'b1);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
